// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and oversampling constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam int         OVERSAMPLE = 16;
  localparam logic [3:0] MID_TICK   = 4'd7;
  localparam logic [3:0] LAST_TICK  = 4'd15;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Latency: 2 clk cycles from d to q.
// Backpressure: none.
// Ports: clk, rst (sync, active-high), d (async in), q (synchronised out).
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receive front end: start-bit qualification, 8N1 LSB-first shift-in, one-entry holding register.
// Latency: rx_valid rises 1 HCLK after the stop-bit sampling tick.
// Backpressure: rx_valid/rx_ready; a byte completing while the holding register is full is dropped with overrun_err.
// Ports: HCLK, HRESET (sync, active-high), b_tick (16x baud pulse), RsRx (async serial in),
//        rx_data/rx_valid/rx_ready (holding register handshake), frame_err, overrun_err, busy.
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic                 b_tick,
  input  logic                 RsRx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);

  // Sample points derived from the oversampling ratio (7 and 15 at 16x).
  localparam logic [3:0] TICK_MID  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] IDX_LAST  = 3'(DATA_BITS - 1);

  logic rx_s;

  rx_state_t            state_q, state_d;
  logic [3:0]           tick_cnt, tick_d;
  logic [2:0]           bit_idx, idx_d;
  logic [DATA_BITS-1:0] shreg, shreg_d;
  logic                 stop_ok, stop_bad;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk (HCLK),
    .rst (HRESET),
    .d   (RsRx),
    .q   (rx_s)
  );

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q  <= IDLE;
      tick_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else begin
      state_q  <= state_d;
      tick_cnt <= tick_d;
      bit_idx  <= idx_d;
      shreg    <= shreg_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_cnt;
    idx_d    = bit_idx;
    shreg_d  = shreg;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    case (state_q)
      IDLE: begin
        // Falling edge is acted on immediately; the tick phase is re-aligned in START.
        if (!rx_s) begin
          state_d = START;
          tick_d  = '0;
        end
      end
      START: begin
        if (b_tick) begin
          if (tick_cnt == TICK_MID) begin
            if (!rx_s) begin
              tick_d  = '0;
              idx_d   = '0;
              state_d = DATA;
            end else begin
              // Line returned high before mid-bit: noise, not a start bit.
              state_d = IDLE;
            end
          end else begin
            tick_d = tick_cnt + 4'd1;
          end
        end
      end
      DATA: begin
        if (b_tick) begin
          if (tick_cnt == TICK_LAST) begin
            shreg_d = {rx_s, shreg[DATA_BITS-1:1]};
            tick_d  = '0;
            if (bit_idx == IDX_LAST) begin
              state_d = STOP;
            end else begin
              idx_d = bit_idx + 3'd1;
            end
          end else begin
            tick_d = tick_cnt + 4'd1;
          end
        end
      end
      STOP: begin
        if (b_tick) begin
          if (tick_cnt == TICK_LAST) begin
            state_d  = IDLE;
            stop_ok  = rx_s;
            stop_bad = !rx_s;
          end else begin
            tick_d = tick_cnt + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Holding register. A simultaneous handshake frees the slot for the new byte.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= stop_bad;
      overrun_err <= stop_ok && rx_valid && !rx_ready;
      if (stop_ok && (!rx_valid || rx_ready)) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer: scoreboard of expected bytes plus directed checks.
// Latency: n/a.
// Backpressure: rx_ready driven by the bench.
module tb_uart_rx_deserializer;

  localparam int BIT_CLKS = 64; // 16 ticks x 4 HCLK per tick

  logic       HCLK = 1'b0;
  logic       HRESET = 1'b1;
  logic       b_tick = 1'b0;
  logic       RsRx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun_err;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;
  int valid_cycles = 0;
  int fe_cycles = 0;
  int ov_cycles = 0;
  logic [7:0] sb[$];

  uart_rx_deserializer #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .b_tick      (b_tick),
    .RsRx        (RsRx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .busy        (busy)
  );

  always #5 HCLK = ~HCLK;

  // 16x baud tick: one HCLK high in every four.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge HCLK);
      #1;
      b_tick = (ph == 3);
      ph = (ph + 1) % 4;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic drive_bit(input logic v, input int clks);
    RsRx = v;
    clk_n(clks);
  endtask

  // 8N1 frame; stop_low > 0 drives the stop bit low for that many clocks then high.
  task automatic send_frame(input logic [7:0] d, input int stop_low);
    drive_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) drive_bit(d[i], BIT_CLKS);
    if (stop_low > 0) begin
      drive_bit(1'b0, stop_low);
      drive_bit(1'b1, BIT_CLKS - stop_low);
    end else begin
      drive_bit(1'b1, BIT_CLKS);
    end
  endtask

  // Output monitor: scoreboard pop on handshake, pulse counting, error exclusivity.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge HCLK);
      if (!HRESET) begin
        if (rx_valid) valid_cycles++;
        if (frame_err) fe_cycles++;
        if (overrun_err) ov_cycles++;
        if (frame_err || overrun_err)
          chk("err_exclusive", {31'b0, frame_err & overrun_err}, 32'd0);
        if (rx_valid && rx_ready) begin
          vectors++;
          assert (sb.size() != 0) else begin
            miscompares++;
            $error("FAIL sb_unexpected: observed byte %0h expected none", rx_data);
          end
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("rx_data_sb", {24'b0, rx_data}, {24'b0, e});
          end
        end
      end
    end
  end

  initial begin
    int vc0, fe0, ov0;

    // Reset state
    clk_n(5);
    chk("rst_rx_data", {24'b0, rx_data}, 32'd0);
    chk("rst_rx_valid", {31'b0, rx_valid}, 32'd0);
    chk("rst_frame_err", {31'b0, frame_err}, 32'd0);
    chk("rst_overrun_err", {31'b0, overrun_err}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    HRESET = 1'b0;
    clk_n(20);

    // Single byte
    rx_ready = 1'b1;
    vc0 = valid_cycles; fe0 = fe_cycles; ov0 = ov_cycles;
    sb.push_back(8'hA5);
    send_frame(8'hA5, 0);
    clk_n(BIT_CLKS);
    chk("single_sb_empty", sb.size(), 32'd0);
    chk("single_valid_cycles", valid_cycles - vc0, 32'd1);
    chk("single_frame_err", fe_cycles - fe0, 32'd0);
    chk("single_overrun", ov_cycles - ov0, 32'd0);
    chk("single_busy", {31'b0, busy}, 32'd0);

    // Glitch: low for 5 ticks only
    vc0 = valid_cycles; fe0 = fe_cycles;
    RsRx = 1'b0;
    clk_n(10);
    chk("glitch_busy_high", {31'b0, busy}, 32'd1);
    clk_n(10);
    RsRx = 1'b1;
    clk_n(60);
    chk("glitch_busy_low", {31'b0, busy}, 32'd0);
    chk("glitch_no_valid", valid_cycles - vc0, 32'd0);
    chk("glitch_no_frame_err", fe_cycles - fe0, 32'd0);

    // Framing error then recovery
    vc0 = valid_cycles; fe0 = fe_cycles; ov0 = ov_cycles;
    send_frame(8'h3C, 48);
    clk_n(2 * BIT_CLKS);
    chk("ferr_pulse", fe_cycles - fe0, 32'd1);
    chk("ferr_no_valid", valid_cycles - vc0, 32'd0);
    chk("ferr_busy", {31'b0, busy}, 32'd0);
    sb.push_back(8'h81);
    send_frame(8'h81, 0);
    clk_n(BIT_CLKS);
    chk("ferr_next_sb_empty", sb.size(), 32'd0);
    chk("ferr_next_valid", valid_cycles - vc0, 32'd1);
    chk("ferr_next_no_ferr", fe_cycles - fe0, 32'd1);
    chk("ferr_no_overrun", ov_cycles - ov0, 32'd0);

    // Overrun
    rx_ready = 1'b0;
    fe0 = fe_cycles; ov0 = ov_cycles;
    sb.push_back(8'h11);
    send_frame(8'h11, 0);
    send_frame(8'h22, 0);
    clk_n(BIT_CLKS);
    chk("ovr_valid_held", {31'b0, rx_valid}, 32'd1);
    chk("ovr_data_held", {24'b0, rx_data}, 32'h11);
    chk("ovr_pulse", ov_cycles - ov0, 32'd1);
    chk("ovr_no_ferr", fe_cycles - fe0, 32'd0);
    rx_ready = 1'b1;
    clk_n(2);
    chk("ovr_valid_cleared", {31'b0, rx_valid}, 32'd0);
    chk("ovr_sb_empty", sb.size(), 32'd0);

    // Back-to-back
    vc0 = valid_cycles; fe0 = fe_cycles; ov0 = ov_cycles;
    sb.push_back(8'h00);
    sb.push_back(8'hFF);
    sb.push_back(8'h55);
    send_frame(8'h00, 0);
    send_frame(8'hFF, 0);
    send_frame(8'h55, 0);
    clk_n(BIT_CLKS);
    chk("b2b_sb_empty", sb.size(), 32'd0);
    chk("b2b_valid_cycles", valid_cycles - vc0, 32'd3);
    chk("b2b_no_ferr", fe_cycles - fe0, 32'd0);
    chk("b2b_no_overrun", ov_cycles - ov0, 32'd0);

    // Reset during data bit 3 of 0xF0
    drive_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 3; i++) drive_bit(1'b0, BIT_CLKS);
    drive_bit(1'b0, BIT_CLKS / 2);
    chk("mrst_busy_before", {31'b0, busy}, 32'd1);
    HRESET = 1'b1;
    clk_n(2);
    chk("mrst_rx_data", {24'b0, rx_data}, 32'd0);
    chk("mrst_rx_valid", {31'b0, rx_valid}, 32'd0);
    chk("mrst_frame_err", {31'b0, frame_err}, 32'd0);
    chk("mrst_overrun_err", {31'b0, overrun_err}, 32'd0);
    chk("mrst_busy", {31'b0, busy}, 32'd0);
    RsRx = 1'b1;
    clk_n(4);
    HRESET = 1'b0;
    clk_n(BIT_CLKS);
    chk("mrst_idle_after", {31'b0, busy}, 32'd0);
    vc0 = valid_cycles; fe0 = fe_cycles; ov0 = ov_cycles;
    sb.push_back(8'h0F);
    send_frame(8'h0F, 0);
    clk_n(BIT_CLKS);
    chk("mrst_next_sb_empty", sb.size(), 32'd0);
    chk("mrst_next_valid", valid_cycles - vc0, 32'd1);
    chk("mrst_next_data", {24'b0, rx_data}, 32'h0F);
    chk("mrst_next_no_err", (fe_cycles - fe0) + (ov_cycles - ov0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
